pattern_seq_arbiter: RTL

- Shared controller for the 1-bit serial pattern output used by the lab state-machine exercises.
- Two requesters each submit a job: pattern bits, length and repeat count.
- Round-robin arbitration picks a winner; the block then plays the winner's pattern on `out`, one bit per clock.
- Signals completion with a one-cycle `done` pulse, then returns `out` to the idle level.

---
 rtl/pattern_seq_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/pattern_seq_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared types and defaults for the serial pattern arbiter and its round-robin helper.
package pattern_seq_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LENW_DEF    = $clog2(MAX_LEN_DEF + 1);
  localparam int REPW_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pattern;
    logic [LENW_DEF-1:0]    len;
    logic [REPW_DEF-1:0]    rep;
  } job_t;

  // Lengths beyond the pattern width would index past the stored bits.
  function automatic logic [LENW_DEF-1:0] clamp_len(input logic [LENW_DEF-1:0] len);
    if (len > LENW_DEF'(MAX_LEN_DEF)) begin
      return LENW_DEF'(MAX_LEN_DEF);
    end
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last index granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (en_i && (req_i != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  // Reset to "index 1 granted last" so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/pattern_seq_arbiter.sv
// Arbitrates two pattern jobs round-robin and plays the winner LSB first on a registered serial output.
module pattern_seq_arbiter
  import pattern_seq_pkg::*;
#(
  parameter int   MAX_LEN    = MAX_LEN_DEF,
  parameter int   LENW       = $clog2(MAX_LEN + 1),
  parameter int   REPW       = REPW_DEF,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [MAX_LEN-1:0] pattern0,
  input  logic [MAX_LEN-1:0] pattern1,
  input  logic [LENW-1:0]   len0,
  input  logic [LENW-1:0]   len1,
  input  logic [REPW-1:0]   rep0,
  input  logic [REPW-1:0]   rep1,
  input  logic              abort,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              aborted,
  output logic              out
);

  localparam int IDXW = $clog2(MAX_LEN);

  state_e          state_q, state_d;
  job_t            job_q, job_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [REPW-1:0] pass_q, pass_d;
  logic            winner_q, winner_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            doneId_q, doneId_d;
  logic            aborted_q, aborted_d;
  logic            out_q, out_d;

  logic [1:0]      arbGnt;
  logic            arbEn;
  job_t            jobSel;
  logic [IDXW-1:0] idxNext;
  logic            lastBit;
  logic            lastPass;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (req),
    .en_i  (arbEn),
    .gnt_o (arbGnt)
  );

  assign arbEn    = (state_q == IDLE);
  assign jobSel   = arbGnt[1] ? '{pattern: pattern1, len: clamp_len(len1), rep: rep1}
                              : '{pattern: pattern0, len: clamp_len(len0), rep: rep0};
  assign idxNext  = idx_q + 1'b1;
  assign lastBit  = ((LENW'(idx_q) + 1'b1) == job_q.len);
  assign lastPass = (pass_q == job_q.rep);

  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    winner_d  = winner_q;
    gnt_d     = 2'b00;
    busy_d    = busy_q;
    done_d    = 1'b0;
    doneId_d  = doneId_q;
    aborted_d = 1'b0;
    out_d     = out_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        out_d  = IDLE_LEVEL;
        if (req != 2'b00) begin
          winner_d = arbGnt[1];
          job_d    = jobSel;
          gnt_d    = arbGnt;
          busy_d   = 1'b1;
          idx_d    = '0;
          pass_d   = '0;
          // A zero-length job still gets its grant but finishes immediately.
          if (jobSel.len == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            doneId_d = arbGnt[1];
          end else begin
            state_d = PLAY;
            out_d   = jobSel.pattern[0];
          end
        end
      end

      PLAY: begin
        if (abort || (lastBit && lastPass)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          doneId_d  = winner_q;
          aborted_d = abort;
          out_d     = IDLE_LEVEL;
        end else if (lastBit) begin
          idx_d  = '0;
          pass_d = pass_q + 1'b1;
          out_d  = job_q.pattern[0];
        end else begin
          idx_d = idxNext;
          out_d = job_q.pattern[idxNext];
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        out_d   = IDLE_LEVEL;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        out_d   = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      job_q     <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      winner_q  <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      doneId_q  <= 1'b0;
      aborted_q <= 1'b0;
      out_q     <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      winner_q  <= winner_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      doneId_q  <= doneId_d;
      aborted_q <= aborted_d;
      out_q     <= out_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = doneId_q;
  assign aborted = aborted_q;
  assign out     = out_q;

endmodule
